// File: rtl/spmv_row_collect.sv
// rtl/spmv_row_collect.sv - SpMV row-result collector: captures two-lane row sums, streams 2*ROWS words
// Optional feature macro: SPMV_COLLECT_SAT_EN (signed saturation instead of truncation)
module spmv_row_collect #(
  parameter int ROWS = 280,
  parameter int IW   = 64,
  parameter int OW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          valid_in,
  input  logic          zeros_in,
  input  logic [IW-1:0] data0,
  input  logic [IW-1:0] data1,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [OW-1:0] m_data,
  output logic          m_last,
  output logic          done,
  output logic          sat_flag,
  output logic          ovf_flag
);

  localparam int N   = 2 * ROWS;
  localparam int IXW = (N > 1) ? $clog2(N) : 1;
  localparam int AW  = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   row_idx;
  logic [AW-1:0]   rd_idx;
  logic [AW-1:0]   wr_hi;
  logic [OW-1:0]   mem [N];
  logic [OW-1:0]   w0, w1;
  logic            event_in, cap, last_row, hs, load;

  assign event_in = valid_in | zeros_in;
  assign cap      = (state == COLLECT) && event_in && !start;
  assign last_row = (row_idx == AW'(ROWS - 1));
  assign hs       = m_valid && m_ready;
  // Fetch the next word whenever the output register is empty or being consumed.
  assign load     = (state == DRAIN) && !start && (!m_valid || m_ready) && (rd_idx < AW'(N));
  assign wr_hi    = row_idx + AW'(ROWS);
  assign done     = (state == DONE);

`ifdef SPMV_COLLECT_SAT_EN
  localparam logic signed [IW-1:0] SMAX = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW-1:0] SMIN = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  logic clip0, clip1;

  // Returns {clipped, value}; clipping is judged on the full signed input.
  function automatic logic [OW:0] sat_conv(input logic [IW-1:0] d);
    logic signed [IW-1:0] s;
    s = signed'(d);
    if (s > SMAX)      sat_conv = {1'b1, 1'b0, {(OW-1){1'b1}}};
    else if (s < SMIN) sat_conv = {1'b1, 1'b1, {(OW-1){1'b0}}};
    else               sat_conv = {1'b0, d[OW-1:0]};
  endfunction

  assign {clip0, w0} = sat_conv(data0);
  assign {clip1, w1} = sat_conv(data1);

  // Sticky saturation flag; an empty-row event writes zeros and never clips.
  always_ff @(posedge clk) begin
    if (rst || start)                                         sat_flag <= 1'b0;
    else if (cap && valid_in && !zeros_in && (clip0 || clip1)) sat_flag <= 1'b1;
  end
`else
  logic unused_hi;
  assign w0        = data0[OW-1:0];
  assign w1        = data1[OW-1:0];
  assign unused_hi = ^{data0[IW-1:OW], data1[IW-1:OW]};
  assign sat_flag  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; start restarts collection from any state.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = COLLECT;
      COLLECT: begin
        if (start)                 state_nx = COLLECT;
        else if (cap && last_row)  state_nx = DRAIN;
      end
      DRAIN: begin
        if (start)                 state_nx = COLLECT;
        else if (hs && m_last)     state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result memory write; empty rows (and collisions) store zero in both lanes.
  always_ff @(posedge clk) begin
    if (cap) begin
      mem[row_idx[IXW-1:0]] <= zeros_in ? '0 : w0;
      mem[wr_hi[IXW-1:0]]   <= zeros_in ? '0 : w1;
    end
  end

  // Row counter, drain read port/output register and stray-event flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_idx  <= '0;
      rd_idx   <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      ovf_flag <= 1'b0;
    end else if (start) begin
      row_idx  <= '0;
      rd_idx   <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (cap) row_idx <= row_idx + AW'(1);
      if (event_in && ((state != COLLECT) || (valid_in && zeros_in))) ovf_flag <= 1'b1;
      if (load) begin
        m_data  <= mem[rd_idx[IXW-1:0]];
        m_valid <= 1'b1;
        m_last  <= (rd_idx == AW'(N - 1));
        rd_idx  <= rd_idx + AW'(1);
      end else if (hs) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule
